// File: rtl/co2_pulse_pkg.sv
// Shared state encodings, safe output levels and counter width for the CO2 gate interlock.
`timescale 1ns/1ps
package co2_pulse_pkg;

    localparam int   CO2_CW             = 16;
    localparam logic CO2_LASER_ON_LEVEL = 1'b1;
    localparam logic CO2_SHUTTER_SAFE   = 1'b0;

    typedef enum logic [2:0] {
        ST_SAFE     = 3'd0,
        ST_READY    = 3'd1,
        ST_ON       = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } co2_state_t;

endpackage

// File: rtl/co2_tick_counter.sv
// Saturating CW-bit tick counter; synchronous clear has priority over the tick enable.
`timescale 1ns/1ps
module co2_tick_counter
    import co2_pulse_pkg::*;
#(
    parameter int CW = CO2_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_tick,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX = {CW{1'b1}};

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_tick && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/co2_gate_interlock.sv
// CO2 laser gate/shutter safety interlock: max emission time, min cool-down, sticky fault. Outputs registered (1 cycle).
// Define CO2_INTERLOCK_SYNC_EN to pass arm/requests/clear through 2-flop synchronisers (3-cycle latency).
`timescale 1ns/1ps
module co2_gate_interlock
    import co2_pulse_pkg::*;
#(
    parameter logic LASER_ON_LEVEL = CO2_LASER_ON_LEVEL,
    parameter logic SHUTTER_SAFE   = CO2_SHUTTER_SAFE,
    parameter int   CW             = CO2_CW
) (
    input  logic          clk_pll,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          arm,
    input  logic          clear_fault,
    input  logic          laser_req,
    input  logic          shutter_req,
    input  logic [CW-1:0] max_on_time,
    input  logic [CW-1:0] min_off_time,
    output logic          laser_gate_out,
    output logic          shutter_out,
    output logic          fault,
    output logic [2:0]    state,
    output logic [CW-1:0] on_count,
    output logic [CW-1:0] shot_count
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic w_arm;
    logic w_laser_req;
    logic w_shutter_req;
    logic w_clear;

`ifdef CO2_INTERLOCK_SYNC_EN
    logic [1:0] r_arm_sync;
    logic [1:0] r_req_sync;
    logic [1:0] r_shut_sync;
    logic [1:0] r_clr_sync;
    logic       r_clr_prev;

    // Synchronisers reset to the safe side so nothing emits while they fill.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_sync  <= 2'b00;
            r_req_sync  <= {2{~LASER_ON_LEVEL}};
            r_shut_sync <= {2{SHUTTER_SAFE}};
            r_clr_sync  <= 2'b00;
            r_clr_prev  <= 1'b0;
        end else begin
            r_arm_sync  <= {r_arm_sync[0], arm};
            r_req_sync  <= {r_req_sync[0], laser_req};
            r_shut_sync <= {r_shut_sync[0], shutter_req};
            r_clr_sync  <= {r_clr_sync[0], clear_fault};
            r_clr_prev  <= r_clr_sync[1];
        end
    end

    assign w_arm         = r_arm_sync[1];
    assign w_laser_req   = r_req_sync[1];
    assign w_shutter_req = r_shut_sync[1];
    assign w_clear       = r_clr_sync[1] & ~r_clr_prev;
`else
    assign w_arm         = arm;
    assign w_laser_req   = laser_req;
    assign w_shutter_req = shutter_req;
    assign w_clear       = clear_fault;
`endif

    co2_state_t    r_state;
    logic          r_gate;
    logic          r_shutter;
    logic          r_fault;
    logic [CW-1:0] r_shot_count;

    logic [CW-1:0] w_on_count;
    logic [CW-1:0] w_off_count;
    logic          w_laser_on;
    logic          w_fault_hit;
    logic          w_off_done;
    logic          w_clear_ok;
    logic          w_on_clr;
    logic          w_on_inc;
    logic          w_off_clr;
    logic          w_off_inc;

    assign w_laser_on  = (w_laser_req == LASER_ON_LEVEL);
    // >= so that lowering the limit below the running count still trips at once.
    assign w_fault_hit = (r_state == ST_ON) && (max_on_time != '0) && (w_on_count >= max_on_time);
    assign w_off_done  = (w_off_count >= min_off_time);
    assign w_clear_ok  = w_clear && !w_laser_on;

    assign w_on_clr  = w_arm && (r_state == ST_READY) && w_laser_on;
    assign w_on_inc  = tick && (r_state == ST_ON) && !w_fault_hit;
    assign w_off_clr = w_arm && (((r_state == ST_ON) && !w_fault_hit && !w_laser_on) ||
                                 ((r_state == ST_FAULT) && w_clear_ok));
    assign w_off_inc = tick && (r_state == ST_COOLDOWN);

    co2_tick_counter #(.CW(CW)) u_on_cnt (
        .i_clk   (clk_pll),
        .i_rst_n (rst_n),
        .i_clr   (w_on_clr),
        .i_tick  (w_on_inc),
        .o_count (w_on_count)
    );

    co2_tick_counter #(.CW(CW)) u_off_cnt (
        .i_clk   (clk_pll),
        .i_rst_n (rst_n),
        .i_clr   (w_off_clr),
        .i_tick  (w_off_inc),
        .o_count (w_off_count)
    );

    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SAFE;
            r_gate       <= ~LASER_ON_LEVEL;
            r_shutter    <= SHUTTER_SAFE;
            r_fault      <= 1'b0;
            r_shot_count <= '0;
        end else if (!w_arm) begin
            r_state   <= ST_SAFE;
            r_gate    <= ~LASER_ON_LEVEL;
            r_shutter <= SHUTTER_SAFE;
        end else begin
            r_gate    <= ~LASER_ON_LEVEL;
            r_shutter <= w_shutter_req;
            case (r_state)
                ST_SAFE: begin
                    // A fault latched before disarming must still be cleared explicitly.
                    if (r_fault) begin
                        r_state   <= ST_FAULT;
                        r_shutter <= SHUTTER_SAFE;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_laser_on) begin
                        r_state <= ST_ON;
                        r_gate  <= LASER_ON_LEVEL;
                    end
                end
                ST_ON: begin
                    if (w_fault_hit) begin
                        r_state   <= ST_FAULT;
                        r_shutter <= SHUTTER_SAFE;
                        r_fault   <= 1'b1;
                    end else if (!w_laser_on) begin
                        r_state      <= ST_COOLDOWN;
                        r_shot_count <= r_shot_count + ONE;
                    end else begin
                        r_gate <= LASER_ON_LEVEL;
                    end
                end
                ST_COOLDOWN: begin
                    if (w_off_done) begin
                        r_state <= ST_READY;
                    end
                end
                ST_FAULT: begin
                    if (w_clear_ok) begin
                        r_state <= ST_COOLDOWN;
                        r_fault <= 1'b0;
                    end else begin
                        r_shutter <= SHUTTER_SAFE;
                    end
                end
                default: begin
                    r_state   <= ST_SAFE;
                    r_shutter <= SHUTTER_SAFE;
                end
            endcase
        end
    end

    assign laser_gate_out = r_gate;
    assign shutter_out    = r_shutter;
    assign fault          = r_fault;
    assign state          = r_state;
    assign on_count       = w_on_count;
    assign shot_count     = r_shot_count;

endmodule

// File: tb/tb_co2_gate_interlock.sv
// Bench for co2_gate_interlock: per-cycle vector table with short limits, then multi-cycle timing sequences.
`timescale 1ns/1ps
module tb_co2_gate_interlock;

`ifdef CO2_INTERLOCK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk_pll = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick;
    logic        tick_l = 1'b0;
    logic        arm = 1'b0;
    logic        clear_fault = 1'b0;
    logic        laser_req = 1'b0;
    logic        shutter_req = 1'b0;
    logic [15:0] max_on_time = 16'd0;
    logic [15:0] min_off_time = 16'd0;
    logic        laser_gate_out;
    logic        shutter_out;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] on_count;
    logic [15:0] shot_count;

    localparam logic [2:0] S_SAFE = 3'd0, S_READY = 3'd1, S_ON = 3'd2, S_COOL = 3'd3, S_FAULT = 3'd4;

    always #5 clk_pll = ~clk_pll;

    // Ticks are delayed like the synchronised inputs so both builds see the same schedule.
`ifdef CO2_INTERLOCK_SYNC_EN
    logic [1:0] tick_pipe = 2'b00;
    always @(posedge clk_pll) tick_pipe <= {tick_pipe[0], tick_l};
    assign tick = tick_pipe[1];
`else
    assign tick = tick_l;
`endif

    co2_gate_interlock dut (
        .clk_pll        (clk_pll),
        .rst_n          (rst_n),
        .tick           (tick),
        .arm            (arm),
        .clear_fault    (clear_fault),
        .laser_req      (laser_req),
        .shutter_req    (shutter_req),
        .max_on_time    (max_on_time),
        .min_off_time   (min_off_time),
        .laser_gate_out (laser_gate_out),
        .shutter_out    (shutter_out),
        .fault          (fault),
        .state          (state),
        .on_count       (on_count),
        .shot_count     (shot_count)
    );

    typedef struct packed {
        logic       arm;
        logic       req;
        logic       sh;
        logic       clr;
        logic       tk;
        logic       e_gate;
        logic       e_sh;
        logic       e_flt;
        logic [2:0] e_st;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic do_reset();
        arm = 1'b0; laser_req = 1'b0; shutter_req = 1'b0; clear_fault = 1'b0; tick_l = 1'b0;
        #2 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    int j, hi, cool, cool_start, on_again, gate_in_cool, lat;

    initial begin
        //               arm req sh clr tk   gate sh flt  state
        vt[0]  = {5'b0_0_1_0_0, 3'b0_0_0, S_SAFE};
        vt[1]  = {5'b1_0_1_0_0, 3'b0_1_0, S_READY};
        vt[2]  = {5'b1_0_0_0_0, 3'b0_0_0, S_READY};
        vt[3]  = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[4]  = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[5]  = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[6]  = {5'b1_0_1_0_0, 3'b0_1_0, S_COOL};
        vt[7]  = {5'b1_1_1_0_1, 3'b0_1_0, S_COOL};
        vt[8]  = {5'b1_1_1_0_1, 3'b0_1_0, S_COOL};
        vt[9]  = {5'b1_1_1_0_0, 3'b0_1_0, S_READY};
        vt[10] = {5'b1_1_1_0_0, 3'b1_1_0, S_ON};
        vt[11] = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[12] = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[13] = {5'b1_1_1_0_1, 3'b1_1_0, S_ON};
        vt[14] = {5'b1_0_1_0_0, 3'b0_0_1, S_FAULT};   // limit and drop together: fault wins
        vt[15] = {5'b1_1_1_1_0, 3'b0_0_1, S_FAULT};
        vt[16] = {5'b1_0_1_0_0, 3'b0_0_1, S_FAULT};
        vt[17] = {5'b1_0_1_1_0, 3'b0_1_0, S_COOL};
        vt[18] = {5'b1_0_1_0_1, 3'b0_1_0, S_COOL};
        vt[19] = {5'b1_0_1_0_1, 3'b0_1_0, S_COOL};
        vt[20] = {5'b1_0_0_0_0, 3'b0_0_0, S_READY};
        vt[21] = {5'b1_1_1_0_0, 3'b1_1_0, S_ON};
        vt[22] = {5'b0_1_1_0_0, 3'b0_0_0, S_SAFE};

        // Reset values
        #3;
        chk("rst_gate", laser_gate_out, 0);
        chk("rst_shutter", shutter_out, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", state, S_SAFE);
        chk("rst_on_count", on_count, 0);
        chk("rst_shot_count", shot_count, 0);

        // Vector table, max=3 min=2
        max_on_time = 16'd3; min_off_time = 16'd2;
        do_reset();
        for (int i = 0; i < NV + LAT - 1; i++) begin
            if (i < NV) begin
                arm = vt[i].arm; laser_req = vt[i].req; shutter_req = vt[i].sh;
                clear_fault = vt[i].clr; tick_l = vt[i].tk;
            end else begin
                clear_fault = 1'b0; tick_l = 1'b0;
            end
            step();
            j = i - (LAT - 1);
            if (j >= 0) begin
                chk($sformatf("vec%0d_gate", j), laser_gate_out, vt[j].e_gate);
                chk($sformatf("vec%0d_shutter", j), shutter_out, vt[j].e_sh);
                chk($sformatf("vec%0d_fault", j), fault, vt[j].e_flt);
                chk($sformatf("vec%0d_state", j), state, vt[j].e_st);
            end
        end
        chk("tbl_shot_count", shot_count, 1);

        // 30-tick shot, max=50 min=20, tick every cycle
        max_on_time = 16'd50; min_off_time = 16'd20;
        do_reset();
        arm = 1'b1; shutter_req = 1'b1;
        repeat (LAT + 2) step();
        chk("shot_ready", state, S_READY);
        tick_l = 1'b1; hi = 0; cool = 0;
        for (int i = 0; i < 120; i++) begin
            laser_req = (i < 30);
            step();
            if (laser_gate_out) hi++;
            if (state == S_COOL) cool++;
        end
        chk("shot_gate_cycles", hi, 30);
        chk("shot_cool_cycles", cool, 21);   // 20 ticks counted, then one edge to leave
        chk("shot_end_state", state, S_READY);
        chk("shot_count_1", shot_count, 1);

        // Over-time fault and clear handling
        do_reset();
        arm = 1'b1; shutter_req = 1'b1;
        repeat (LAT + 2) step();
        laser_req = 1'b1; tick_l = 1'b1;
        for (int i = 0; i < 300 && fault !== 1'b1; i++) step();
        chk("flt_fault", fault, 1);
        chk("flt_state", state, S_FAULT);
        chk("flt_gate", laser_gate_out, 0);
        chk("flt_shutter", shutter_out, 0);
        chk("flt_on_count", on_count, 50);
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        repeat (LAT + 2) step();
        chk("flt_clr_req_hi_state", state, S_FAULT);
        chk("flt_clr_req_hi_fault", fault, 1);
        laser_req = 1'b0;
        repeat (LAT + 2) step();
        chk("flt_no_clr_state", state, S_FAULT);
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        repeat (LAT - 1) step();
        chk("flt_cleared_state", state, S_COOL);
        chk("flt_cleared_fault", fault, 0);
        chk("flt_cleared_shutter", shutter_out, 1);
        for (int i = 0; i < 100 && state !== S_READY; i++) step();
        chk("flt_back_ready", state, S_READY);

        // Re-request 5 ticks into cooldown
        do_reset();
        arm = 1'b1;
        repeat (LAT + 2) step();
        tick_l = 1'b1; cool_start = -1; on_again = -1; gate_in_cool = 0;
        for (int i = 0; i < 100; i++) begin
            laser_req = (i < 10) || (i >= 15);
            step();
            if (state == S_COOL && cool_start < 0) cool_start = i;
            if (state == S_COOL && laser_gate_out) gate_in_cool++;
            if (cool_start >= 0 && on_again < 0 && state == S_ON && laser_gate_out) on_again = i;
        end
        chk("cool_gate_held_off", gate_in_cool, 0);
        chk("cool_reon_delay", on_again - cool_start, 22);   // 21 COOLDOWN + 1 READY

        // Request-to-pin latency, then arm dropped mid-ON
        do_reset();
        arm = 1'b1; shutter_req = 1'b1;
        repeat (LAT + 2) step();
        laser_req = 1'b1; lat = 0;
        for (int i = 0; i < 10 && laser_gate_out !== 1'b1; i++) begin
            step();
            lat++;
        end
        chk("req_latency", lat, LAT);
        repeat (3) step();
        arm = 1'b0;
        repeat (LAT) step();
        chk("disarm_gate", laser_gate_out, 0);
        chk("disarm_shutter", shutter_out, 0);
        chk("disarm_state", state, S_SAFE);
        chk("disarm_shot_count", shot_count, 0);

        // No limit: 70000 ticks of emission saturates on_count
        max_on_time = 16'd0;
        do_reset();
        arm = 1'b1; shutter_req = 1'b1;
        repeat (LAT + 2) step();
        laser_req = 1'b1; tick_l = 1'b1;
        repeat (70000) step();
        chk("nolim_fault", fault, 0);
        chk("nolim_state", state, S_ON);
        chk("nolim_on_sat", on_count, 65535);

        // Asynchronous reset mid-ON
        #2 rst_n = 1'b0;
        #1;
        chk("areset_gate", laser_gate_out, 0);
        chk("areset_shutter", shutter_out, 0);
        chk("areset_state", state, S_SAFE);
        chk("areset_on_count", on_count, 0);
        arm = 1'b0; laser_req = 1'b0; tick_l = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_state", state, S_SAFE);
        chk("post_reset_on_count", on_count, 0);
        chk("post_reset_shot", shot_count, 0);

        // Disarm while faulted keeps the fault flag
        max_on_time = 16'd3;
        do_reset();
        arm = 1'b1; shutter_req = 1'b1;
        repeat (LAT + 2) step();
        laser_req = 1'b1; tick_l = 1'b1;
        for (int i = 0; i < 50 && fault !== 1'b1; i++) step();
        arm = 1'b0;
        repeat (LAT) step();
        chk("safe_fault_state", state, S_SAFE);
        chk("safe_fault_flag", fault, 1);
        chk("safe_fault_gate", laser_gate_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
